// File: rtl/hazard_ctrl.sv
// Pipeline hazard / PC-redirect controller: freeze on dmem wait, redirect with pending
// target across imem wait states, load-use bubble. Perf counters under HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             redirect_valid_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  input  logic             dx_mem_rd_i,
  input  logic [4:0]       dx_rd_addr_i,
  input  logic [4:0]       fd_rs1_addr_i,
  input  logic [4:0]       fd_rs2_addr_i,
  input  logic             fd_rs1_used_i,
  input  logic             fd_rs2_used_i,
  output logic             pc_sel_o,
  output logic [XLEN-1:0]  pc_target_o,
  output logic             pc_en_o,
  output logic             fd_en_o,
  output logic             dx_en_o,
  output logic             fd_flush_o,
  output logic             dx_flush_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN, RDR_WAIT, FREEZE} state_t;

  state_t          state, state_nxt, ret_state, ret_nxt, eff;
  logic [XLEN-1:0] pending_pc, pending_nxt;
  logic            load_use;

  assign load_use = dx_mem_rd_i && (dx_rd_addr_i != '0) &&
                    ((fd_rs1_used_i && (fd_rs1_addr_i == dx_rd_addr_i)) ||
                     (fd_rs2_used_i && (fd_rs2_addr_i == dx_rd_addr_i)));

  // Leaving FREEZE is Mealy: the release cycle already behaves as the saved state.
  assign eff = (state == FREEZE) ? ret_state : state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= RUN;
      ret_state  <= RUN;
      pending_pc <= '0;
    end else begin
      state      <= state_nxt;
      ret_state  <= ret_nxt;
      pending_pc <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ret_nxt     = ret_state;
    pending_nxt = pending_pc;
    pc_sel_o    = 1'b0;
    pc_target_o = '0;
    pc_en_o     = 1'b0;
    fd_en_o     = 1'b0;
    dx_en_o     = 1'b0;
    fd_flush_o  = 1'b0;
    dx_flush_o  = 1'b0;
    if (!rst_ni) begin
      fd_flush_o = 1'b1;
      dx_flush_o = 1'b1;
    end else if (!dmem_ready_i) begin
      state_nxt = FREEZE;
      ret_nxt   = eff;
    end else if (eff == RDR_WAIT) begin
      // Flushes are constant here so imem_ready_i never reaches them combinationally.
      pc_sel_o    = 1'b1;
      pc_target_o = pending_pc;
      pc_en_o     = imem_ready_i;
      fd_en_o     = 1'b1;
      dx_en_o     = 1'b1;
      fd_flush_o  = 1'b1;
      dx_flush_o  = 1'b1;
      state_nxt   = imem_ready_i ? RUN : RDR_WAIT;
    end else if (redirect_valid_i) begin
      pc_sel_o    = 1'b1;
      pc_target_o = redirect_pc_i;
      pc_en_o     = imem_ready_i;
      fd_en_o     = 1'b1;
      dx_en_o     = 1'b1;
      fd_flush_o  = 1'b1;
      dx_flush_o  = 1'b1;
      state_nxt   = imem_ready_i ? RUN : RDR_WAIT;
      if (!imem_ready_i) pending_nxt = redirect_pc_i;
    end else if (load_use) begin
      dx_en_o    = 1'b1;
      dx_flush_o = 1'b1;
      state_nxt  = RUN;
    end else begin
      pc_en_o    = imem_ready_i;
      fd_en_o    = 1'b1;
      dx_en_o    = 1'b1;
      fd_flush_o = !imem_ready_i;
      state_nxt  = RUN;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic             redirect_acc, stall_evt;
  logic [CNT_W-1:0] redirect_cnt, stall_cnt;

  assign redirect_acc = dmem_ready_i && (eff == RUN) && redirect_valid_i;
  assign stall_evt    = !dmem_ready_i || ((eff == RUN) && !redirect_valid_i && load_use);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (redirect_acc) redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (stall_evt)    stall_cnt    <= stall_cnt + CNT_W'(1);
    end
  end

  assign redirect_cnt_o = redirect_cnt;
  assign stall_cnt_o    = stall_cnt;
`else
  assign redirect_cnt_o = '0;
  assign stall_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares every output.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_ready_i = 1'b1;
  logic        dmem_ready_i = 1'b1;
  logic        dx_mem_rd_i = 1'b0;
  logic [4:0]  dx_rd_addr_i = '0;
  logic [4:0]  fd_rs1_addr_i = '0;
  logic [4:0]  fd_rs2_addr_i = '0;
  logic        fd_rs1_used_i = 1'b0;
  logic        fd_rs2_used_i = 1'b0;
  logic        pc_sel_o, pc_en_o, fd_en_o, dx_en_o, fd_flush_o, dx_flush_o;
  logic [31:0] pc_target_o, redirect_cnt_o, stall_cnt_o;

  hazard_ctrl #(.XLEN(32), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .dx_mem_rd_i(dx_mem_rd_i), .dx_rd_addr_i(dx_rd_addr_i),
    .fd_rs1_addr_i(fd_rs1_addr_i), .fd_rs2_addr_i(fd_rs2_addr_i),
    .fd_rs1_used_i(fd_rs1_used_i), .fd_rs2_used_i(fd_rs2_used_i),
    .pc_sel_o(pc_sel_o), .pc_target_o(pc_target_o), .pc_en_o(pc_en_o),
    .fd_en_o(fd_en_o), .dx_en_o(dx_en_o),
    .fd_flush_o(fd_flush_o), .dx_flush_o(dx_flush_o),
    .redirect_cnt_o(redirect_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    logic        sel;
    logic [31:0] tgt;
    logic        pcen, fden, dxen, fdfl, dxfl;
    logic [31:0] rc, sc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input int unsigned idx, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", idx, name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.idx, "pc_sel",       {31'd0, pc_sel_o},   {31'd0, e.sel});
      chk(e.idx, "pc_target",    pc_target_o,         e.tgt);
      chk(e.idx, "pc_en",        {31'd0, pc_en_o},    {31'd0, e.pcen});
      chk(e.idx, "fd_en",        {31'd0, fd_en_o},    {31'd0, e.fden});
      chk(e.idx, "dx_en",        {31'd0, dx_en_o},    {31'd0, e.dxen});
      chk(e.idx, "fd_flush",     {31'd0, fd_flush_o}, {31'd0, e.fdfl});
      chk(e.idx, "dx_flush",     {31'd0, dx_flush_o}, {31'd0, e.dxfl});
      chk(e.idx, "redirect_cnt", redirect_cnt_o,      e.rc);
      chk(e.idx, "stall_cnt",    stall_cnt_o,         e.sc);
    end
  end

  // One vector per cycle, driven 1 time unit after the rising edge.
  task automatic v(input logic r, input logic rv, input logic [31:0] rpc,
                   input logic im, input logic dm, input logic mrd, input logic [4:0] rd,
                   input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                   input logic esel, input logic [31:0] etgt, input logic epc,
                   input logic efd, input logic edx, input logic effl, input logic edfl,
                   input int unsigned erc, input int unsigned esc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_ni = r; redirect_valid_i = rv; redirect_pc_i = rpc;
    imem_ready_i = im; dmem_ready_i = dm; dx_mem_rd_i = mrd; dx_rd_addr_i = rd;
    fd_rs1_addr_i = r1; fd_rs1_used_i = u1; fd_rs2_addr_i = r2; fd_rs2_used_i = u2;
    e.idx = n_vec; e.sel = esel; e.tgt = etgt; e.pcen = epc; e.fden = efd; e.dxen = edx;
    e.fdfl = effl; e.dxfl = edfl;
`ifdef HAZARD_CTRL_PERF_EN
    e.rc = erc; e.sc = esc;
`else
    e.rc = '0; e.sc = '0;
`endif
    sb.push_back(e);
    n_vec++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected done", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    //  r rv rpc        im dm mrd rd r1 u1 r2 u2   sel tgt        pc fd dx ffl dfl rc sc
    v(0, 0, 32'h0,     1, 1, 0,  0, 0, 0, 0, 0,   0, 32'h0,     0, 0, 0, 1,  1,  0, 0); // reset
    v(1, 0, 32'h0,     1, 1, 0,  0, 0, 0, 0, 0,   0, 32'h0,     1, 1, 1, 0,  0,  0, 0); // normal
    v(1, 1, 32'h40,    1, 1, 0,  0, 0, 0, 0, 0,   1, 32'h40,    1, 1, 1, 1,  1,  0, 0); // redirect ready
    v(1, 0, 32'h0,     0, 1, 0,  0, 0, 0, 0, 0,   0, 32'h0,     0, 1, 1, 1,  0,  1, 0); // no fetch
    v(1, 1, 32'h100,   0, 1, 0,  0, 0, 0, 0, 0,   1, 32'h100,   0, 1, 1, 1,  1,  1, 0); // redirect wait
    v(1, 1, 32'h200,   0, 1, 0,  0, 0, 0, 0, 0,   1, 32'h100,   0, 1, 1, 1,  1,  2, 0);
    v(1, 1, 32'h200,   0, 1, 0,  0, 0, 0, 0, 0,   1, 32'h100,   0, 1, 1, 1,  1,  2, 0);
    v(1, 1, 32'h200,   1, 1, 0,  0, 0, 0, 0, 0,   1, 32'h100,   1, 1, 1, 1,  1,  2, 0); // load pending
    v(1, 0, 32'h0,     1, 1, 0,  0, 0, 0, 0, 0,   0, 32'h0,     1, 1, 1, 0,  0,  2, 0);
    v(1, 0, 32'h0,     1, 1, 1,  5, 3, 1, 5, 1,   0, 32'h0,     0, 0, 1, 0,  1,  2, 0); // load-use rs2
    v(1, 0, 32'h0,     1, 1, 1,  0, 0, 1, 0, 1,   0, 32'h0,     1, 1, 1, 0,  0,  2, 1); // rd=0
    v(1, 0, 32'h0,     1, 1, 1,  7, 7, 0, 2, 1,   0, 32'h0,     1, 1, 1, 0,  0,  2, 1); // rs1 unused
    v(1, 0, 32'h0,     1, 1, 1,  7, 7, 1, 0, 0,   0, 32'h0,     0, 0, 1, 0,  1,  2, 1); // load-use rs1
    v(1, 0, 32'h0,     1, 1, 0,  7, 7, 1, 0, 0,   0, 32'h0,     1, 1, 1, 0,  0,  2, 2);
    v(1, 1, 32'h300,   0, 1, 0,  0, 0, 0, 0, 0,   1, 32'h300,   0, 1, 1, 1,  1,  2, 2); // to RDR_WAIT
    v(1, 1, 32'h500,   1, 0, 0,  0, 0, 0, 0, 0,   0, 32'h0,     0, 0, 0, 0,  0,  3, 2); // freeze
    v(1, 1, 32'h500,   1, 0, 0,  0, 0, 0, 0, 0,   0, 32'h0,     0, 0, 0, 0,  0,  3, 3);
    v(1, 0, 32'h0,     0, 1, 0,  0, 0, 0, 0, 0,   1, 32'h300,   0, 1, 1, 1,  1,  3, 4); // resume wait
    v(1, 0, 32'h0,     1, 1, 0,  0, 0, 0, 0, 0,   1, 32'h300,   1, 1, 1, 1,  1,  3, 4);
    v(1, 0, 32'h0,     1, 1, 0,  0, 0, 0, 0, 0,   0, 32'h0,     1, 1, 1, 0,  0,  3, 4);
    v(1, 1, 32'h80,    1, 0, 0,  0, 0, 0, 0, 0,   0, 32'h0,     0, 0, 0, 0,  0,  3, 4); // freeze in RUN
    v(1, 1, 32'h80,    1, 1, 0,  0, 0, 0, 0, 0,   1, 32'h80,    1, 1, 1, 1,  1,  3, 5);
    v(1, 1, 32'hC0,    1, 1, 1,  5, 5, 1, 0, 0,   1, 32'hC0,    1, 1, 1, 1,  1,  4, 5); // redirect+load-use
    v(1, 0, 32'h0,     1, 1, 0,  0, 0, 0, 0, 0,   0, 32'h0,     1, 1, 1, 0,  0,  5, 5);
    v(1, 1, 32'h700,   0, 1, 0,  0, 0, 0, 0, 0,   1, 32'h700,   0, 1, 1, 1,  1,  5, 5); // to RDR_WAIT
    v(0, 0, 32'h0,     0, 1, 0,  0, 0, 0, 0, 0,   0, 32'h0,     0, 0, 0, 1,  1,  0, 0); // async reset
    v(1, 0, 32'h0,     1, 1, 0,  0, 0, 0, 0, 0,   0, 32'h0,     1, 1, 1, 0,  0,  0, 0); // pending dropped
    v(1, 0, 32'h0,     0, 1, 0,  0, 0, 0, 0, 0,   0, 32'h0,     0, 1, 1, 1,  0,  0, 0);
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
